// File: rtl/pwm_duty_bank_pkg.sv
// Shared constants, register-select type and address decode helper for the PWM duty bank.
package pwm_duty_bank_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DUTY_W = 8;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;
  localparam int OFF_STEP   = 8;
  localparam int OFF_STATUS = 9;
  localparam int WIN_SIZE   = 10;

  typedef enum logic [1:0] {
    SEL_TARGET,
    SEL_STEP,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  // Offsets NUM_CH..7 fall in the window but map to nothing.
  function automatic reg_sel_e decode_sel(input logic [ADDR_W-1:0] off, input int num_ch);
    if (off < ADDR_W'(num_ch))           return SEL_TARGET;
    else if (off == ADDR_W'(OFF_STEP))   return SEL_STEP;
    else if (off == ADDR_W'(OFF_STATUS)) return SEL_STATUS;
    else                                 return SEL_NONE;
  endfunction

endpackage

// File: rtl/pwm_duty_bank_if.sv
// Data-memory bus as seen by the duty bank: processor drives write/address, bank returns hit/read data.
interface pwm_duty_bank_if;
  logic        wren;
  logic [11:0] addr;
  logic [31:0] data_in;
  logic        hit;
  logic [31:0] rd_data;

  modport master (output wren, output addr, output data_in, input hit, input rd_data);
  modport slave  (input wren, input addr, input data_in, output hit, output rd_data);
endinterface

// File: rtl/pwm_duty_bank_slew_lane.sv
// One channel's active duty: moves toward target on frame ticks, limited by step (0 = jump).
module pwm_slew_lane #(
  parameter int DUTY_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [DUTY_W-1:0] step_i,
  input  logic              frame_tick_i,
  output logic [DUTY_W-1:0] active_o,
  output logic              settled_o
);

  logic [DUTY_W-1:0] active_q, active_d;
  logic [DUTY_W:0]   sum, diff, tgt_x;

  // One extra bit so overshoot and borrow are visible instead of wrapping.
  assign tgt_x = {1'b0, target_i};
  assign sum   = {1'b0, active_q} + {1'b0, step_i};
  assign diff  = {1'b0, active_q} - {1'b0, step_i};

  always_comb begin
    active_d = active_q;
    if (frame_tick_i) begin
      if (step_i == '0)
        active_d = target_i;
      else if (active_q < target_i)
        active_d = (sum > tgt_x) ? target_i : sum[DUTY_W-1:0];
      else if (active_q > target_i)
        active_d = (diff[DUTY_W] || (diff < tgt_x)) ? target_i : diff[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) active_q <= '0;
    else         active_q <= active_d;
  end

  assign active_o  = active_q;
  assign settled_o = (active_q == target_i);

endmodule

// File: rtl/pwm_duty_bank.sv
// Memory-mapped duty register bank: CPU targets, frame counter and read-back; per-channel slew lanes.
module pwm_duty_bank
  import pwm_duty_bank_pkg::*;
#(
  parameter int                NUM_CH       = DEF_NUM_CH,
  parameter int                DUTY_W       = DEF_DUTY_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'hFF0,
  parameter int                FRAME_CYCLES = 256
) (
  input  logic                     clock,
  input  logic                     resetn,
  pwm_duty_bank_if.slave           bus,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic                     frame_tick,
  output logic [NUM_CH-1:0]        settled
);

  logic [ADDR_W-1:0] off;
  reg_sel_e          sel;
  logic              wr_en;
  logic [DUTY_W-1:0] target_q [NUM_CH];
  logic [DUTY_W-1:0] step_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign off      = bus.addr - BASE_ADDR;
  assign bus.hit  = (off < ADDR_W'(WIN_SIZE));
  assign sel      = decode_sel(off, NUM_CH);
  assign wr_en    = bus.wren && bus.hit;
  assign frame_tick = (cnt_q == CNT_W'(FRAME_CYCLES - 1));

  always_comb begin
    rd_data_d = '0;
    case (sel)
      SEL_TARGET: begin
        for (int i = 0; i < NUM_CH; i++)
          if (off == ADDR_W'(i)) rd_data_d[DUTY_W-1:0] = target_q[i];
      end
      SEL_STEP:   rd_data_d[DUTY_W-1:0] = step_q;
      SEL_STATUS: begin
        rd_data_d[31:16]       = cnt_q;
        rd_data_d[NUM_CH-1:0]  = settled;
      end
      default:    rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) target_q[i] <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      cnt_q     <= frame_tick ? '0 : cnt_q + 1'b1;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en && (sel == SEL_TARGET) && (off == ADDR_W'(i)))
          target_q[i] <= bus.data_in[DUTY_W-1:0];
      if (wr_en && (sel == SEL_STEP))
        step_q <= bus.data_in[DUTY_W-1:0];
    end
  end

  assign bus.rd_data = rd_data_q;

  // Lanes see pre-edge target/step, so a write on the tick cycle lands one frame later.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    pwm_slew_lane #(.DUTY_W(DUTY_W)) u_lane (
      .clock        (clock),
      .resetn       (resetn),
      .target_i     (target_q[g]),
      .step_i       (step_q),
      .frame_tick_i (frame_tick),
      .active_o     (duty_out[g*DUTY_W +: DUTY_W]),
      .settled_o    (settled[g])
    );
  end

endmodule
